// File: rtl/trap_ctrl.sv
// trap_ctrl: machine-mode trap/interrupt sequencer driving the MSTATUS/MCAUSE/MEPC/MTVAL write ports and the fetch redirect.
// Optional feature: define TRAP_CTRL__VECTORED_EN for vectored interrupt targets (mtvec mode 2'b01).
module trap_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            timeint,
    input  logic            swint,
    input  logic            extint,
    input  logic [XLEN-1:0] mstatus,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] pc,
    input  logic            boundary,
    input  logic            debug,
    input  logic            exc_valid,
    input  logic [4:0]      exc_cause,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret,
    output logic [XLEN-1:0] mstatus_in,
    output logic            mstatus_write,
    output logic [XLEN-1:0] mcause_in,
    output logic            mcause_write,
    output logic [XLEN-1:0] mepc_in,
    output logic            mepc_write,
    output logic [XLEN-1:0] mtval_in,
    output logic            mtval_write,
    output logic [XLEN-1:0] mip_out,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENTER,
        S_RETURN,
        S_REDIRECT
    } state_e;

    state_e          state_q, state_d;
    logic            ext_meta_q, ext_s_q;
    logic            irq_q, irq_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic [XLEN-1:0] target_q, target_d;
    logic [XLEN-1:0] pend;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] vec_off;
    logic [4:0]      irq_code;
    logic            take_irq;

    always_comb begin
        mip_out     = '0;
        mip_out[11] = ext_s_q;
        mip_out[7]  = timeint;
        mip_out[3]  = swint;
    end

    assign pend     = mip_out & mie;
    assign take_irq = boundary && !debug && mstatus[3] && (pend != '0);
    // Interrupt priority: external, then software, then timer.
    assign irq_code = pend[11] ? 5'd11 : (pend[3] ? 5'd3 : 5'd7);
    assign base     = {mtvec[XLEN-1:2], 2'b00};

`ifdef TRAP_CTRL__VECTORED_EN
    assign vec_off = (irq_q && mtvec[1:0] == 2'b01)
                     ? {{(XLEN-7){1'b0}}, cause_q[4:0], 2'b00} : '0;
`else
    logic unused_mode;
    assign unused_mode = ^{mtvec[1:0], irq_q};
    assign vec_off     = '0;
`endif

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        irq_d         = irq_q;
        cause_d       = cause_q;
        epc_d         = epc_q;
        tval_d        = tval_q;
        target_d      = target_q;
        mstatus_in    = mstatus;
        mstatus_write = 1'b0;
        mcause_write  = 1'b0;
        mepc_write    = 1'b0;
        mtval_write   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (exc_valid) begin
                    state_d = S_ENTER;
                    irq_d   = 1'b0;
                    cause_d = {{(XLEN-5){1'b0}}, exc_cause};
                    tval_d  = exc_tval;
                    epc_d   = pc;
                end else if (mret) begin
                    state_d = S_RETURN;
                end else if (take_irq) begin
                    state_d = S_ENTER;
                    irq_d   = 1'b1;
                    cause_d = {1'b1, {(XLEN-6){1'b0}}, irq_code};
                    tval_d  = '0;
                    epc_d   = pc;
                end
            end
            S_ENTER: begin
                mstatus_write    = 1'b1;
                mcause_write     = 1'b1;
                mepc_write       = 1'b1;
                mtval_write      = 1'b1;
                mstatus_in[7]    = mstatus[3];
                mstatus_in[3]    = 1'b0;
                mstatus_in[12:11] = 2'b11;
                target_d         = base + vec_off;
                state_d          = S_REDIRECT;
            end
            S_RETURN: begin
                mstatus_write    = 1'b1;
                mstatus_in[3]    = mstatus[7];
                mstatus_in[7]    = 1'b1;
                mstatus_in[12:11] = 2'b11;
                target_d         = mepc;
                state_d          = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (redirect_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments and a synchronous reset that clears every register, including the latched trap data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ext_meta_q <= 1'b0;
            ext_s_q    <= 1'b0;
            irq_q      <= 1'b0;
            cause_q    <= '0;
            epc_q      <= '0;
            tval_q     <= '0;
            target_q   <= '0;
        end else begin
            state_q    <= state_d;
            ext_meta_q <= extint;
            ext_s_q    <= ext_meta_q;
            irq_q      <= irq_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            tval_q     <= tval_d;
            target_q   <= target_d;
        end
    end

    assign mcause_in      = cause_q;
    assign mepc_in        = epc_q;
    assign mtval_in       = tval_q;
    assign redirect_valid = (state_q == S_REDIRECT);
    assign redirect_pc    = target_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized events checked against a rule-level model.
module tb_trap_ctrl;

    localparam int K_NONE = 0;
    localparam int K_TRAP = 1;
    localparam int K_MRET = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        timeint, swint, extint;
    logic [31:0] mstatus, mie, mtvec, mepc, pc;
    logic        boundary, debug, exc_valid, mret;
    logic [4:0]  exc_cause;
    logic [31:0] exc_tval;
    logic [31:0] mstatus_in, mcause_in, mepc_in, mtval_in, mip_out, redirect_pc;
    logic        mstatus_write, mcause_write, mepc_write, mtval_write;
    logic        redirect_valid, redirect_ready, busy;

    int checks   = 0;
    int failures = 0;

    trap_ctrl #(.XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .timeint        (timeint),
        .swint          (swint),
        .extint         (extint),
        .mstatus        (mstatus),
        .mie            (mie),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .pc             (pc),
        .boundary       (boundary),
        .debug          (debug),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_tval       (exc_tval),
        .mret           (mret),
        .mstatus_in     (mstatus_in),
        .mstatus_write  (mstatus_write),
        .mcause_in      (mcause_in),
        .mcause_write   (mcause_write),
        .mepc_in        (mepc_in),
        .mepc_write     (mepc_write),
        .mtval_in       (mtval_in),
        .mtval_write    (mtval_write),
        .mip_out        (mip_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: decide the IDLE outcome from the architectural rules, assuming extint has been stable long enough.
    function automatic void model(output int kind, output logic [31:0] cause, output logic [31:0] tval,
                                  output logic [31:0] epc, output logic [31:0] mst, output logic [31:0] tgt);
        logic [31:0] pending;
        logic [31:0] tvec_base;
        int          prio[3];
        int          code;
        prio      = '{11, 3, 7};
        pending   = 32'h0;
        pending[11] = extint;
        pending[7]  = timeint;
        pending[3]  = swint;
        pending   = pending & mie;
        tvec_base = mtvec & ~32'h3;
        kind  = K_NONE;
        cause = 32'h0;
        tval  = 32'h0;
        epc   = pc;
        mst   = mstatus;
        tgt   = tvec_base;
        code  = -1;
        if (exc_valid) begin
            kind  = K_TRAP;
            cause = 32'(exc_cause);
            tval  = exc_tval;
        end else if (mret) begin
            kind = K_MRET;
            tgt  = mepc;
        end else if (boundary && !debug && mstatus[3] && pending != 32'h0) begin
            foreach (prio[i]) if (code < 0 && pending[prio[i]]) code = prio[i];
            kind  = K_TRAP;
            cause = 32'h8000_0000 | 32'(code);
`ifdef TRAP_CTRL__VECTORED_EN
            if (mtvec[1:0] == 2'b01) tgt = tvec_base + 32'(4 * code);
`endif
        end
        if (kind == K_TRAP) begin
            mst[7]     = mstatus[3];
            mst[3]     = 1'b0;
            mst[12:11] = 2'b11;
        end else if (kind == K_MRET) begin
            mst[3]     = mstatus[7];
            mst[7]     = 1'b1;
            mst[12:11] = 2'b11;
        end
    endfunction

    // Event inputs are set in IDLE; this walks the expected ENTER/RETURN -> REDIRECT -> IDLE sequence.
    task automatic run(input string tag, input int kind, input logic [31:0] cause, input logic [31:0] tval,
                       input logic [31:0] epc, input logic [31:0] mst, input logic [31:0] tgt,
                       input int ready_delay);
        tick();
        exc_valid = 1'b0;
        mret      = 1'b0;
        boundary  = 1'b0;
        if (kind == K_NONE) begin
            check({tag, "/idle_busy"}, busy, 1'b0);
            check({tag, "/idle_mstatus_write"}, mstatus_write, 1'b0);
            check({tag, "/idle_mcause_write"}, mcause_write, 1'b0);
            return;
        end
        check({tag, "/busy"}, busy, 1'b1);
        check({tag, "/early_redirect"}, redirect_valid, 1'b0);
        check({tag, "/mstatus_write"}, mstatus_write, 1'b1);
        check({tag, "/mstatus_in"}, mstatus_in, mst);
        if (kind == K_TRAP) begin
            check({tag, "/mcause_write"}, mcause_write, 1'b1);
            check({tag, "/mepc_write"}, mepc_write, 1'b1);
            check({tag, "/mtval_write"}, mtval_write, 1'b1);
            check({tag, "/mcause_in"}, mcause_in, cause);
            check({tag, "/mepc_in"}, mepc_in, epc);
            check({tag, "/mtval_in"}, mtval_in, tval);
        end else begin
            check({tag, "/mcause_write"}, mcause_write, 1'b0);
            check({tag, "/mepc_write"}, mepc_write, 1'b0);
            check({tag, "/mtval_write"}, mtval_write, 1'b0);
        end
        tick();
        check({tag, "/redirect_valid"}, redirect_valid, 1'b1);
        check({tag, "/redirect_pc"}, redirect_pc, tgt);
        check({tag, "/strobe_off"}, mstatus_write, 1'b0);
        for (int d = 0; d < ready_delay; d++) begin
            tick();
            check({tag, "/hold_valid"}, redirect_valid, 1'b1);
            check({tag, "/hold_pc"}, redirect_pc, tgt);
        end
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        check({tag, "/done_busy"}, busy, 1'b0);
        check({tag, "/done_valid"}, redirect_valid, 1'b0);
    endtask

    initial begin
        int          kind;
        logic [31:0] m_cause, m_tval, m_epc, m_mst, m_tgt;
        logic [31:0] vec_tgt;

        rst_n = 1'b0; timeint = 1'b0; swint = 1'b0; extint = 1'b0;
        mstatus = '0; mie = '0; mtvec = '0; mepc = '0; pc = '0;
        boundary = 1'b0; debug = 1'b0; exc_valid = 1'b0; exc_cause = '0; exc_tval = '0;
        mret = 1'b0; redirect_ready = 1'b0;
        repeat (3) tick();
        check("reset/busy", busy, 1'b0);
        check("reset/redirect_valid", redirect_valid, 1'b0);
        check("reset/redirect_pc", redirect_pc, 32'h0);
        check("reset/mstatus_write", mstatus_write, 1'b0);
        check("reset/mcause_write", mcause_write, 1'b0);
        check("reset/mip_out", mip_out, 32'h0);
        rst_n = 1'b1;
        tick();

        // Synchronous exception.
        mstatus = 32'h8; mtvec = 32'h80; pc = 32'h100; exc_tval = 32'hDEAD; exc_cause = 5'd2; exc_valid = 1'b1;
        run("exc", K_TRAP, 32'h2, 32'hDEAD, 32'h100, 32'h1880, 32'h80, 0);

        // Timer interrupt with mtvec in vectored mode.
`ifdef TRAP_CTRL__VECTORED_EN
        vec_tgt = 32'h21C;
`else
        vec_tgt = 32'h200;
`endif
        mtvec = 32'h201; mie = 32'h80; timeint = 1'b1; boundary = 1'b1; pc = 32'h300;
        run("vec_timer", K_TRAP, 32'h8000_0007, 32'h0, 32'h300, 32'h1880, vec_tgt, 1);
        timeint = 1'b0;

        // External beats timer once it clears the synchronizer.
        mie = 32'h888; mtvec = 32'h400; boundary = 1'b0;
        extint = 1'b1; timeint = 1'b1;
        tick();
        check("sync/one_cycle", mip_out, 32'h80);
        tick();
        check("sync/two_cycles", mip_out, 32'h880);
        boundary = 1'b1; pc = 32'h404;
        run("prio_ext", K_TRAP, 32'h8000_000B, 32'h0, 32'h404, 32'h1880, 32'h400, 0);

        // Exception wins over pending interrupts and ignores vectored mode.
        mtvec = 32'h401; boundary = 1'b1; exc_valid = 1'b1; exc_cause = 5'd5; exc_tval = 32'h1234; pc = 32'h500;
        run("exc_over_irq", K_TRAP, 32'h5, 32'h1234, 32'h500, 32'h1880, 32'h400, 2);

        // Masking: global disable, debug mode, no boundary.
        swint = 1'b1;
        for (int c = 0; c < 3; c++) begin
            mstatus  = (c == 0) ? 32'h0 : 32'h8;
            debug    = (c == 1);
            boundary = (c != 2);
            for (int n = 0; n < 20; n++) begin
                tick();
                check($sformatf("mask%0d/busy", c), busy, 1'b0);
                check($sformatf("mask%0d/strobe", c), mstatus_write | mcause_write, 1'b0);
            end
        end
        extint = 1'b0; swint = 1'b0; timeint = 1'b0; debug = 1'b0; boundary = 1'b0;
        repeat (3) tick();

        // MRET with a slow fetch.
        mstatus = 32'h80; mepc = 32'h104; mret = 1'b1;
        run("mret", K_MRET, 32'h0, 32'h0, 32'h0, 32'h1888, 32'h104, 3);

        // Reset while the redirect is pending, then a clean exception.
        mstatus = 32'h8; mtvec = 32'h80; pc = 32'h200; exc_cause = 5'd3; exc_valid = 1'b1;
        tick();
        exc_valid = 1'b0;
        tick();
        check("rst_mid/redirect_before", redirect_valid, 1'b1);
        rst_n = 1'b0;
        tick();
        check("rst_mid/redirect_valid", redirect_valid, 1'b0);
        check("rst_mid/busy", busy, 1'b0);
        check("rst_mid/strobe", mstatus_write, 1'b0);
        rst_n = 1'b1;
        exc_valid = 1'b1; exc_cause = 5'd4; exc_tval = 32'h55; pc = 32'h208;
        run("rst_after", K_TRAP, 32'h4, 32'h55, 32'h208, 32'h1880, 32'h80, 0);

        // Randomized events against the reference model.
        for (int it = 0; it < 200; it++) begin
            exc_valid = 1'b0; mret = 1'b0; boundary = 1'b0; redirect_ready = 1'b0;
            extint = 1'($urandom);
            repeat (3) tick();
            check($sformatf("rnd%0d/mip11", it), mip_out[11], extint);
            mstatus   = $urandom;
            mie       = $urandom;
            mtvec     = $urandom;
            mepc      = $urandom;
            pc        = $urandom;
            exc_cause = 5'($urandom);
            exc_tval  = $urandom;
            timeint   = 1'($urandom);
            swint     = 1'($urandom);
            debug     = ($urandom_range(0, 4) == 0);
            boundary  = ($urandom_range(0, 3) != 0);
            exc_valid = ($urandom_range(0, 3) == 0);
            mret      = ($urandom_range(0, 3) == 0);
            model(kind, m_cause, m_tval, m_epc, m_mst, m_tgt);
            run($sformatf("rnd%0d", it), kind, m_cause, m_tval, m_epc, m_mst, m_tgt, int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap and interrupt sequencer that sits directly downstream of the CSR block. It consumes `timeint` and the MSTATUS/MIE/MTVEC/MEPC values, together with core exception and `mret` events. It arbitrates trap entry and return, drives the hardware write ports of MSTATUS/MCAUSE/MEPC/MTVAL, and issues a PC redirect to fetch.

## Interface
Parameters:
- `XLEN`, default `ISA__XLEN` (32): data width.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `timeint` in 1: machine timer pending, driven by the CSR block.
- `swint` in 1: machine software interrupt pending.
- `extint` in 1: external interrupt, asynchronous.
- `mstatus` in XLEN: current MSTATUS.
- `mie` in XLEN: current MIE.
- `mtvec` in XLEN: current MTVEC.
- `mepc` in XLEN: current MEPC.
- `pc` in XLEN: PC of the instruction at the boundary or faulting.
- `boundary` in 1: core is at an instruction boundary and can accept an interrupt.
- `debug` in 1: core is in debug mode.
- `exc_valid` in 1: synchronous exception.
- `exc_cause` in 5: exception code.
- `exc_tval` in XLEN: trap value.
- `mret` in 1: MRET is executing.
- `mstatus_in` out XLEN: next MSTATUS.
- `mstatus_write` out 1: MSTATUS write strobe.
- `mcause_in` out XLEN: next MCAUSE.
- `mcause_write` out 1: MCAUSE write strobe.
- `mepc_in` out XLEN: next MEPC.
- `mepc_write` out 1: MEPC write strobe.
- `mtval_in` out XLEN: next MTVAL.
- `mtval_write` out 1: MTVAL write strobe.
- `mip_out` out XLEN: MIP read value.
- `redirect_valid` out 1: redirect request to fetch.
- `redirect_pc` out XLEN: redirect target.
- `redirect_ready` in 1: fetch accepts the redirect.
- `busy` out 1: pipeline must stall.

## Operation
- `extint` passes through a 2-flop synchronizer, `ext_s`.
- `mip_out` = bit11 `ext_s`, bit7 `timeint`, bit3 `swint`; all other bits 0.
- `pend` = `mip_out & mie`.
- States: IDLE, ENTER, RETURN, REDIRECT.
- IDLE decisions, evaluated in this order:
  - `exc_valid`: go to ENTER with an exception. Latch cause = {0, `exc_cause`}, tval = `exc_tval`, epc = `pc`.
  - Else `mret`: go to RETURN.
  - Else if `boundary && !debug && mstatus[3] && pend!=0`: go to ENTER with an interrupt. Cause = {1, code}, code = 11 > 3 > 7 by priority. tval = 0, epc = `pc`.
- ENTER, one cycle:
  - Assert all four write strobes.
  - `mstatus_in` = `mstatus` with MPIE[7] ← MIE[3], MIE ← 0, MPP[12:11] ← 2'b11.
  - Latch target = {`mtvec[XLEN-1:2]`,2'b00}.
  - Go to REDIRECT.
- RETURN, one cycle:
  - Assert `mstatus_write` only.
  - `mstatus_in`: MIE ← MPIE, MPIE ← 1, MPP ← 2'b11.
  - Latch target = `mepc`.
  - Go to REDIRECT.
- REDIRECT:
  - Hold `redirect_valid` and `redirect_pc` stable until `redirect_ready`, then go to IDLE.
- `busy` = state != IDLE.
- Inputs are ignored outside IDLE. The core holds `exc_valid`/`mret` stalled by `busy`.
- Write strobes are 0 in every state except ENTER/RETURN. `*_in` values are don't-care when the strobe is 0.
- The trap unit has priority over CSR instructions on the shared registers. The CSR block flags any clash.
- Arithmetic: vector target = base + (code << 2), truncated to XLEN. Wrap-around is ignored.

## Timing
- Reset:
  - State is IDLE and synchronizer flops are 0.
  - All strobes, `redirect_valid` and `busy` are 0.
  - `redirect_pc` and latched cause/epc/tval are 0.
- Latency:
  - Event in IDLE at cycle N: write strobes at N+1, `redirect_valid` from N+2.
  - `extint` reaches `ext_s` 2 cycles after assertion.
  - `timeint`/`swint` are used in the same cycle.
- `redirect_ready` high in the first REDIRECT cycle: return to IDLE next cycle. Minimum trap occupancy is 3 cycles.
- An interrupt that deasserts after the IDLE decision is still taken.
- Reset asserted in any state returns to IDLE on the next edge, deasserting `redirect_valid` and strobes.

## Configuration
- `TRAP_CTRL__VECTORED_EN` defined:
  - `mtvec[1:0]`==2'b01 with an interrupt gives target base+4×code.
  - Exceptions always go to base.
  - Mode 2'b1x is treated as direct.
- Undefined: mode bits are ignored and every trap targets base.

## Test plan
- Exception:
  - Stimulus: `exc_valid`, cause 2, `pc`=0x100, tval=0xDEAD, `mtvec`=0x80, MSTATUS MIE=1.
  - Response: at N+1, `mcause_in`=2, `mepc_in`=0x100, `mtval_in`=0xDEAD, `mstatus_in` MIE=0/MPIE=1/MPP=3. Redirect to 0x80 at N+2.
- Vectored timer interrupt (macro on):
  - Stimulus: `mtvec`=0x201, `mie`[7]=1, `timeint`=1, `boundary`=1.
  - Response: `mcause_in`=0x80000007, `mtval_in`=0, redirect 0x21C. With the macro off, redirect 0x200.
- Priority and synchronizer latency:
  - Stimulus: `extint` and `timeint` both raised, all enabled.
  - Response: `mip_out`[11] rises 2 cycles later, then cause 0x8000000B is taken.
  - Stimulus: `exc_valid` together with a pending interrupt. Response: the exception is taken.
- Masking:
  - Stimulus: pending enabled interrupt with MSTATUS.MIE=0, or `debug`=1, or `boundary`=0.
  - Response: no strobe, `busy`=0 for 20 cycles.
- MRET:
  - Stimulus: MSTATUS MPIE=1, MIE=0, `mepc`=0x104.
  - Response: only `mstatus_write`, with MIE=1/MPIE=1. Redirect 0x104 held through 3 cycles of `redirect_ready`=0.
- Reset mid-REDIRECT:
  - Stimulus: `rst_n`=0 while `redirect_valid`=1.
  - Response: next cycle `redirect_valid`=0, `busy`=0, IDLE. A following exception proceeds normally.
